// File: rtl/riscv_program_loader.sv
// ---------------------------------------------------------------------------
// riscv_program_loader
//
// Writer side of the instruction memory. A host or UART delivers a program
// as a little-endian byte stream framed as:
//   [4-byte word count N] [N x 4-byte instruction words]
// Each word is written to instruction memory in order, starting at BASE_ADDR.
// This matches the instruction streamer's PC>>2 word indexing, so the
// streamer can run the program from PC=0 once loading completes.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start                one-cycle pulse; arms the loader (ignored while busy)
//   in_valid/in_data     byte stream in
//   in_ready             loader accepts a byte this cycle
//   mem_we/mem_addr/     memory write request, byte address, instruction word
//   mem_wdata
//   mem_ready            memory accepts the write this cycle
//   busy/done/error      status: loading / program written / length too big
//   word_count           words written since the loader was last armed
//   checksum             mod-2^32 sum of the words written
//   dbg_state            current FSM state (encoding of state_e)
//
// Handshakes (both directions use the same rule):
//   A transfer happens at a posedge where valid and ready are both high.
//   valid, once raised, holds its payload stable until that edge; ready may
//   depend on state only, never on valid. Bytes: in_valid/in_ready.
//   Writes: mem_we acts as valid against mem_ready.
//
// BASE_ADDR must be 4-byte aligned. mem_addr cannot wrap within the legal
// range because oversized lengths are rejected before any write.
// ---------------------------------------------------------------------------
module riscv_program_loader #(
  parameter int unsigned MEM_WORDS = 32'd10000000,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] word_count,
  output logic [31:0] checksum,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] sum_q, sum_d;
  logic [1:0]  idx_q, idx_d;

  logic        byte_fire;
  logic        write_fire;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic [31:0] count_inc;

  // Status and handshake outputs are decoded from the registered state only.
  assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA);
  assign mem_we     = (state_q == S_WRITE);
  assign busy       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign checksum   = sum_q;
  assign dbg_state  = state_q;

  assign byte_fire  = in_valid && in_ready;
  assign write_fire = mem_we && mem_ready;

  // Little-endian assembly: each new byte enters at the top and older bytes
  // shift down, so after four bytes the first one sits in [7:0].
  assign len_next   = {in_data, len_q[31:8]};
  assign word_next  = {in_data, wdata_q[31:8]};
  assign count_inc  = count_q + 32'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    count_d = count_q;
    sum_d   = sum_q;
    idx_d   = idx_q;

    unique case (state_q)
      S_IDLE: begin
        len_d   = '0;
        idx_d   = '0;
        count_d = '0;
        sum_d   = '0;
        addr_d  = BASE_ADDR;
        if (start) state_d = S_LEN;
      end

      S_LEN: begin
        if (byte_fire) begin
          len_d = len_next;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (len_next == 32'd0)           state_d = S_DONE;
            else if (len_next > MEM_WORDS)   state_d = S_ERR;
            else                             state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (byte_fire) begin
          wdata_d = word_next;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Address and data are held until the memory takes the word.
        if (write_fire) begin
          count_d = count_inc;
          sum_d   = sum_q + wdata_q;
          addr_d  = addr_q + 32'd4;
          state_d = (count_inc == len_q) ? S_DONE : S_DATA;
        end
      end

      S_DONE, S_ERR: begin
        // Single-cycle rearm: perform the idle clears and go straight to LEN.
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          count_d = '0;
          sum_d   = '0;
          addr_d  = BASE_ADDR;
          state_d = S_LEN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/riscv_program_loader.md
Name: riscv_program_loader

Overview:
- Writer side of the instruction memory: receives a program as a little-endian byte stream and writes it into the instruction memory.
- Each program is framed as a 4-byte word count followed by that many 32-bit instruction words.
- Writes are sequential from BASE_ADDR, matching the instruction streamer's PC>>2 word indexing, so the streamer can then run from PC=0.
- Sits between a host/UART byte source and the instruction memory write port.

Parameters:
- MEM_WORDS, 10000000, capacity of instruction memory in 32-bit words; larger programs are rejected.
- BASE_ADDR, 32'h00000000, byte address of first written word; must be 4-byte aligned.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms loader for a new program.
- in_valid  input  1  byte present on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts byte this cycle.
- mem_we  output  1  memory write request.
- mem_addr  output  32  byte address of write (BASE_ADDR + 4*index).
- mem_wdata  output  32  assembled instruction word.
- mem_ready  input  1  memory accepts write this cycle.
- busy  output  1  high in LEN, DATA, WRITE.
- done  output  1  program fully written.
- error  output  1  length exceeded MEM_WORDS.
- word_count  output  32  words written so far.
- checksum  output  32  mod-2^32 sum of written words.

Behaviour:
- Registered FSM with states IDLE, LEN, DATA, WRITE, DONE, ERR.
- Reset (takes priority over every other input, any state):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - busy=0, done=0, error=0, word_count=0, checksum=0.
  - Internal byte index=0, length=0.
- Byte handshake: a byte is consumed when in_valid && in_ready at posedge. in_ready=1 only in LEN and DATA.
- IDLE:
  - start -> LEN.
  - Clear word_count, checksum, length and byte index; set mem_addr=BASE_ADDR.
- LEN:
  - Accept 4 bytes, little-endian: the first byte is length[7:0].
  - On the 4th byte, compare the complete length:
    - length==0 -> DONE.
    - length>MEM_WORDS -> ERR.
    - otherwise -> DATA.
- DATA:
  - Accept bytes into a word shift register, little-endian: the first byte is wdata[7:0].
  - On the 4th byte -> WRITE, with mem_wdata holding the full word that cycle.
- WRITE:
  - mem_we=1; mem_addr and mem_wdata are held stable until mem_ready.
  - On the mem_we && mem_ready edge:
    - word_count+=1; checksum+=mem_wdata (wraps mod 2^32); mem_addr+=4.
    - New word_count==length -> DONE; else -> DATA.
  - mem_we is deasserted the cycle after acceptance.
  - Minimum cost: 1 WRITE cycle per word, so each word takes at least 5 clocks.
- DONE:
  - done=1, in_ready=0; word_count and checksum stay frozen.
  - start -> IDLE-clear actions, then LEN in the same transition (single-cycle rearm).
- ERR: error=1, in_ready=0; start rearms exactly as in DONE.
- start while busy is ignored.
- Gaps in in_valid stall progress without loss.
- Bytes arriving in IDLE, DONE or ERR are not consumed (in_ready=0).
- mem_addr does not wrap within the legal range, because length<=MEM_WORDS.
- Reset mid-load aborts the load. Memory already written is left unchanged; the loader does not scrub it.

Test Plan:
- Reset, start, stream 02 00 00 00 | 13 05 10 00 | 93 05 20 00 with mem_ready=1 -> writes 0x00100513@0x0 and 0x00200593@0x4; done=1, word_count=2, checksum=0x00300AA6.
- Start, stream 00 00 00 00 -> DONE right after the 4th byte; no mem_we pulse; word_count=0.
- Build with MEM_WORDS=4; stream length 05 00 00 00 -> error=1, in_ready=0, no writes. Then start plus a valid 1-word frame -> done=1, error=0.
- Hold mem_ready=0 for 3 cycles during the first WRITE -> mem_we, mem_addr=0x0 and mem_wdata stay stable for 4 cycles; in_ready=0 throughout; exactly one word is committed.
- Toggle in_valid randomly; also pulse start mid-DATA -> same memory image and checksum as the gapless run; the start pulse has no effect.
- Assert reset after 1.5 words -> all outputs return to reset values, state=IDLE. A new start plus full frame loads correctly from BASE_ADDR.
